wb_slave_interconnect: RTL and testbench

//  Parametrised Wishbone slave-side interconnect for the AL4S3B FPGA fabric. It sits between the AHB-to-FPGA

---
 rtl/wb_ic_defs.sv | 24 ++
 rtl/wb_slave_interconnect_if.sv | 24 ++
 rtl/wb_ic_timeout.sv | 31 +++
 rtl/wb_slave_interconnect.sv | 163 ++++++++++++++++
 tb/tb_wb_slave_interconnect.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ic_defs.sv
// Shared definitions for the Wishbone slave-side interconnect:
// FSM encoding, default read value and counter widths.
package wb_ic_defs;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DFLT_ACK,
        WAIT_DROP
    } state_e;

    localparam logic [31:0] DFLT_RD_VAL = 32'hBADFABAC;
    localparam int          TOCNT_W     = 16;

    // Slot field is ADR[APERWIDTH-1:APERSIZE+2]
    function automatic int slot_msb(input int aperwidth);
        return aperwidth - 1;
    endfunction

    function automatic int slot_lsb(input int apersize);
        return apersize + 2;
    endfunction

endpackage

// File: rtl/wb_slave_interconnect_if.sv
// Bridge-side Wishbone bus between the AHB-to-FPGA bridge (master)
// and the slave interconnect (slave).
interface wb_slave_interconnect_if #(
    parameter int APERWIDTH = 17
);
    logic [APERWIDTH-1:0] WBs_ADR;
    logic                 WBs_CYC;
    logic                 WBs_STB;
    logic                 WBs_WE;
    logic                 WBs_RD;
    logic [3:0]           WBs_BYTE_STB;
    logic [31:0]          WBs_DAT;
    logic                 WBs_ACK;

    modport master (
        output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB,
        input  WBs_DAT, WBs_ACK
    );

    modport slave (
        input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB,
        output WBs_DAT, WBs_ACK
    );
endinterface

// File: rtl/wb_ic_timeout.sv
// Clear/enable cycle counter with terminal-count flag used to bound
// how long the interconnect waits for a slave acknowledge.
module wb_ic_timeout #(
    parameter int W  = 3,
    parameter int TC = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == W'(TC - 1));
endmodule

// File: rtl/wb_slave_interconnect.sv
// Wishbone slave-side interconnect: slot decode, read mux, default ACK.
// Define WB_IC_ERR_CAPTURE_EN to add Err_Adr_o/Err_WE_o error capture.
module wb_slave_interconnect
    import wb_ic_defs::*;
#(
    parameter int                        APERWIDTH          = 17,
    parameter int                        APERSIZE           = 10,
    parameter int                        NUM_SLV            = 4,
    parameter logic [NUM_SLV*APERWIDTH-1:0] SLV_BASE_ADDR   = '0,
    parameter logic [NUM_SLV*4-1:0]      SLV_WR_BSTB_MASK   = '1,
    parameter int                        TIMEOUT_CYCLES     = 7,
    parameter int                        CNTR_WIDTH         = 3,
    parameter logic [31:0]               DEFAULT_READ_VALUE = DFLT_RD_VAL
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    wb_slave_interconnect_if.slave wbs,
    output logic [NUM_SLV-1:0]     WBm_CYC_o,
    input  logic [NUM_SLV*32-1:0]  WBm_DAT_i,
    input  logic [NUM_SLV-1:0]     WBm_ACK_i,
    output logic [TOCNT_W-1:0]     Timeout_Cnt_o
`ifdef WB_IC_ERR_CAPTURE_EN
    ,
    output logic [APERWIDTH-1:0]   Err_Adr_o,
    output logic                   Err_WE_o
`endif
);
    localparam int SMSB = slot_msb(APERWIDTH);
    localparam int SLSB = slot_lsb(APERSIZE);
    localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, dec_idx;
    logic                hit_q, dec_hit;
    logic [TOCNT_W-1:0]  tocnt_q;
    logic [NUM_SLV-1:0]  slot_hit;
    logic [31:0]         slv_dat [NUM_SLV];
    logic                req, tc, cnt_clr, cnt_en, ack, sel_ack;
    logic [31:0]         dat;
    logic                unused_adr_lo;

    assign unused_adr_lo = ^wbs.WBs_ADR[SLSB-1:0];
    assign req = wbs.WBs_CYC & wbs.WBs_STB;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
        localparam int B = g * APERWIDTH;
        logic adr_match, wr_ok;
        assign adr_match = wbs.WBs_ADR[SMSB:SLSB] ==
                           SLV_BASE_ADDR[B+SMSB:B+SLSB];
        assign wr_ok = |(wbs.WBs_BYTE_STB & SLV_WR_BSTB_MASK[g*4 +: 4]);
        assign slot_hit[g] = adr_match &
                             (wbs.WBs_RD | (wbs.WBs_WE & wr_ok));
        assign slv_dat[g] = WBm_DAT_i[g*32 +: 32];
    end

    // Descending scan so the lowest matching slot wins on overlap
    always_comb begin
        dec_idx = '0;
        dec_hit = 1'b0;
        for (int s = NUM_SLV - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                dec_idx = IDXW'(s);
                dec_hit = 1'b1;
            end
        end
    end

    wb_ic_timeout #(
        .W  (CNTR_WIDTH),
        .TC (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (WBs_CLK_i),
        .rst_i (WBs_RST_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    assign sel_ack = WBm_ACK_i[idx_q];

    always_comb begin
        state_d   = state_q;
        WBm_CYC_o = '0;
        ack       = 1'b0;
        dat       = DEFAULT_READ_VALUE;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (req)
                    state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!wbs.WBs_CYC) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (hit_q) begin
                        WBm_CYC_o[idx_q] = 1'b1;
                        dat              = slv_dat[idx_q];
                    end
                    // Slave ACK beats a timeout landing on the same cycle
                    if (hit_q && sel_ack) begin
                        ack     = 1'b1;
                        state_d = WAIT_DROP;
                    end else if (tc) begin
                        state_d = DFLT_ACK;
                    end
                end
            end
            DFLT_ACK: begin
                ack     = 1'b1;
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!wbs.WBs_STB)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                idx_q <= dec_idx;
                hit_q <= dec_hit;
            end
            if (state_q == DFLT_ACK && tocnt_q != '1)
                tocnt_q <= tocnt_q + 1'b1;
        end
    end

`ifdef WB_IC_ERR_CAPTURE_EN
    logic [APERWIDTH-1:0] err_adr_q;
    logic                 err_we_q;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            err_adr_q <= '0;
            err_we_q  <= 1'b0;
        end else if (state_q == DFLT_ACK) begin
            err_adr_q <= wbs.WBs_ADR;
            err_we_q  <= wbs.WBs_WE;
        end
    end

    assign Err_Adr_o = err_adr_q;
    assign Err_WE_o  = err_we_q;
`endif

    assign wbs.WBs_ACK   = ack;
    assign wbs.WBs_DAT   = dat;
    assign Timeout_Cnt_o = tocnt_q;
endmodule

// File: tb/tb_wb_slave_interconnect.sv
// Directed self-checking bench for wb_slave_interconnect (3 slots).
// Error-capture checks are compiled in when WB_IC_ERR_CAPTURE_EN is set.
module tb_wb_slave_interconnect;
    localparam int AW = 17;
    localparam int NS = 3;
    localparam logic [31:0] DFLT = 32'hBADFABAC;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   cyc_o;
    logic [NS*32-1:0] sdat;
    logic [NS-1:0]   sack;
    logic [15:0]     tcnt;
`ifdef WB_IC_ERR_CAPTURE_EN
    logic [AW-1:0]   err_adr;
    logic            err_we;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_slave_interconnect_if #(.APERWIDTH(AW)) bus ();

    wb_slave_interconnect #(
        .APERWIDTH          (AW),
        .APERSIZE           (10),
        .NUM_SLV            (NS),
        .SLV_BASE_ADDR      ({17'h03000, 17'h01000, 17'h00000}),
        .SLV_WR_BSTB_MASK   ({4'hF, 4'h1, 4'hF}),
        .TIMEOUT_CYCLES     (7),
        .CNTR_WIDTH         (3),
        .DEFAULT_READ_VALUE (DFLT)
    ) dut (
        .WBs_CLK_i     (clk),
        .WBs_RST_i     (rst),
        .wbs           (bus),
        .WBm_CYC_o     (cyc_o),
        .WBm_DAT_i     (sdat),
        .WBm_ACK_i     (sack),
        .Timeout_Cnt_o (tcnt)
`ifdef WB_IC_ERR_CAPTURE_EN
        ,
        .Err_Adr_o     (err_adr),
        .Err_WE_o      (err_we)
`endif
    );

    task automatic bus_idle();
        bus.WBs_CYC      = 1'b0;
        bus.WBs_STB      = 1'b0;
        bus.WBs_WE       = 1'b0;
        bus.WBs_RD       = 1'b0;
        bus.WBs_BYTE_STB = 4'h0;
        sack             = '0;
    endtask

    task automatic bus_req(input logic [AW-1:0] adr, input logic we,
                           input logic rd, input logic [3:0] bstb);
        bus.WBs_ADR      = adr;
        bus.WBs_WE       = we;
        bus.WBs_RD       = rd;
        bus.WBs_BYTE_STB = bstb;
        bus.WBs_CYC      = 1'b1;
        bus.WBs_STB      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.WBs_ADR = '0;
        bus_idle();
        sdat = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        repeat (2) @(negedge clk);
        total++;
        if (cyc_o !== 3'b000) begin
            bad++; $display("FAIL rst_cyc got=%b exp=000", cyc_o);
        end
        total++;
        if (bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL rst_ack got=%b exp=0", bus.WBs_ACK);
        end
        total++;
        if (bus.WBs_DAT !== DFLT) begin
            bad++; $display("FAIL rst_dat got=%h exp=%h", bus.WBs_DAT, DFLT);
        end
        total++;
        if (tcnt !== 16'd0) begin
            bad++; $display("FAIL rst_tcnt got=%0d exp=0", tcnt);
        end
`ifdef WB_IC_ERR_CAPTURE_EN
        total++;
        if (err_adr !== '0 || err_we !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%h/%b exp=0/0", err_adr, err_we);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_read_slot1();
        @(negedge clk);
        bus_req(17'h01004, 1'b0, 1'b1, 4'hF);
        @(negedge clk);
        total++;
        if (cyc_o !== 3'b010) begin
            bad++; $display("FAIL t1_cyc got=%b exp=010", cyc_o);
        end
        total++;
        if (bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL t1_early_ack got=%b exp=0", bus.WBs_ACK);
        end
        @(negedge clk);
        @(negedge clk);
        sack[1] = 1'b1;
        sdat[63:32] = 32'h0000_0041;
        #1;
        total++;
        if (bus.WBs_ACK !== 1'b1 || bus.WBs_DAT !== 32'h41) begin
            bad++; $display("FAIL t1_ack got=%b/%h exp=1/00000041", bus.WBs_ACK, bus.WBs_DAT);
        end
        @(negedge clk);
        sack = '0;
        bus_idle();
        #1;
        total++;
        if (bus.WBs_ACK !== 1'b0 || cyc_o !== 3'b000) begin
            bad++; $display("FAIL t1_after got=%b/%b exp=0/000", bus.WBs_ACK, cyc_o);
        end
        @(negedge clk);
        total++;
        if (bus.WBs_DAT !== DFLT || cyc_o !== 3'b000) begin
            bad++; $display("FAIL t1_idle got=%h/%b exp=%h/000", bus.WBs_DAT, cyc_o, DFLT);
        end
    endtask

    task automatic test_masked_write();
        @(negedge clk);
        bus_req(17'h01000, 1'b1, 1'b0, 4'b0010);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (cyc_o !== 3'b000) begin
                bad++; $display("FAIL t2_cyc k=%0d got=%b exp=000", k, cyc_o);
            end
            total++;
            if (bus.WBs_ACK !== (k == 8)) begin
                bad++; $display("FAIL t2_ack k=%0d got=%b exp=%b", k, bus.WBs_ACK, k == 8);
            end
        end
        @(negedge clk);
        total++;
        if (bus.WBs_ACK !== 1'b0 || tcnt !== 16'd1) begin
            bad++; $display("FAIL t2_cnt got=%b/%0d exp=0/1", bus.WBs_ACK, tcnt);
        end
`ifdef WB_IC_ERR_CAPTURE_EN
        total++;
        if (err_adr !== 17'h01000 || err_we !== 1'b1) begin
            bad++; $display("FAIL t2_err got=%h/%b exp=01000/1", err_adr, err_we);
        end
`endif
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_unmapped_read();
        bus_req(17'h05000, 1'b0, 1'b1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (bus.WBs_ACK !== (k == 8)) begin
                bad++; $display("FAIL t3_ack k=%0d got=%b exp=%b", k, bus.WBs_ACK, k == 8);
            end
        end
        total++;
        if (bus.WBs_DAT !== DFLT) begin
            bad++; $display("FAIL t3_dat got=%h exp=%h", bus.WBs_DAT, DFLT);
        end
        @(negedge clk);
        total++;
        if (tcnt !== 16'd2) begin
            bad++; $display("FAIL t3_cnt got=%0d exp=2", tcnt);
        end
`ifdef WB_IC_ERR_CAPTURE_EN
        total++;
        if (err_adr !== 17'h05000 || err_we !== 1'b0) begin
            bad++; $display("FAIL t3_err got=%h/%b exp=05000/0", err_adr, err_we);
        end
`endif
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_ack_at_timeout();
        bus_req(17'h00010, 1'b0, 1'b1, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (bus.WBs_ACK !== 1'b0 || cyc_o !== 3'b001) begin
                bad++; $display("FAIL t4_wait k=%0d got=%b/%b exp=0/001", k, bus.WBs_ACK, cyc_o);
            end
        end
        @(negedge clk);
        sack[0] = 1'b1;
        sdat[31:0] = 32'h1234_5678;
        #1;
        total++;
        if (bus.WBs_ACK !== 1'b1 || bus.WBs_DAT !== 32'h1234_5678) begin
            bad++; $display("FAIL t4_ack got=%b/%h exp=1/12345678", bus.WBs_ACK, bus.WBs_DAT);
        end
        @(negedge clk);
        sack = '0;
        #1;
        total++;
        if (bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL t4_no_dflt got=%b exp=0", bus.WBs_ACK);
        end
        @(negedge clk);
        total++;
        if (bus.WBs_ACK !== 1'b0 || tcnt !== 16'd2) begin
            bad++; $display("FAIL t4_cnt got=%b/%0d exp=0/2", bus.WBs_ACK, tcnt);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_stb_hold_and_abort();
        bus_req(17'h03000, 1'b0, 1'b1, 4'hF);
        @(negedge clk);
        sack[2] = 1'b1;
        sdat[95:64] = 32'hCAFE_0002;
        #1;
        total++;
        if (cyc_o !== 3'b100 || bus.WBs_ACK !== 1'b1) begin
            bad++; $display("FAIL t5_ack got=%b/%b exp=100/1", cyc_o, bus.WBs_ACK);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sack = '0;
            #1;
            total++;
            if (cyc_o !== 3'b000 || bus.WBs_ACK !== 1'b0) begin
                bad++; $display("FAIL t5_hold k=%0d got=%b/%b exp=000/0", k, cyc_o, bus.WBs_ACK);
            end
        end
        bus.WBs_STB = 1'b0;
        @(negedge clk);
        bus.WBs_STB = 1'b1;
        @(negedge clk);
        total++;
        if (cyc_o !== 3'b100) begin
            bad++; $display("FAIL t5_reissue got=%b exp=100", cyc_o);
        end
        bus_idle();
        #1;
        total++;
        if (cyc_o !== 3'b000 || bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL t5_abort got=%b/%b exp=000/0", cyc_o, bus.WBs_ACK);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (bus.WBs_ACK !== 1'b0) begin
                bad++; $display("FAIL t5_no_ack k=%0d got=%b exp=0", k, bus.WBs_ACK);
            end
        end
        total++;
        if (tcnt !== 16'd2) begin
            bad++; $display("FAIL t5_cnt got=%0d exp=2", tcnt);
        end
    endtask

    task automatic test_reset_mid();
        bus_req(17'h01008, 1'b0, 1'b1, 4'hF);
        @(negedge clk);
        total++;
        if (cyc_o !== 3'b010) begin
            bad++; $display("FAIL t6_cyc got=%b exp=010", cyc_o);
        end
        sack[1] = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (cyc_o !== 3'b000 || bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL t6_rst got=%b/%b exp=000/0", cyc_o, bus.WBs_ACK);
        end
        total++;
        if (bus.WBs_DAT !== DFLT || tcnt !== 16'd0) begin
            bad++; $display("FAIL t6_rst_val got=%h/%0d exp=%h/0", bus.WBs_DAT, tcnt, DFLT);
        end
`ifdef WB_IC_ERR_CAPTURE_EN
        total++;
        if (err_adr !== '0 || err_we !== 1'b0) begin
            bad++; $display("FAIL t6_err got=%h/%b exp=0/0", err_adr, err_we);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        @(negedge clk);
        bus_req(17'h03004, 1'b0, 1'b1, 4'hF);
        @(negedge clk);
        total++;
        if (cyc_o !== 3'b100) begin
            bad++; $display("FAIL t6_redec got=%b exp=100", cyc_o);
        end
        sack[2] = 1'b1;
        sdat[95:64] = 32'h0000_0777;
        #1;
        total++;
        if (bus.WBs_ACK !== 1'b1 || bus.WBs_DAT !== 32'h777) begin
            bad++; $display("FAIL t6_ack got=%b/%h exp=1/00000777", bus.WBs_ACK, bus.WBs_DAT);
        end
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        total++;
        if (cyc_o !== 3'b000 || bus.WBs_ACK !== 1'b0) begin
            bad++; $display("FAIL t6_end got=%b/%b exp=000/0", cyc_o, bus.WBs_ACK);
        end
    endtask

    initial begin
        test_reset();
        test_read_slot1();
        test_masked_write();
        test_unmapped_read();
        test_ack_at_timeout();
        test_stb_hold_and_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
